// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Latency: response registered, visible 1 cycle after the request is accepted.
// Backpressure: rsp_* held while rsp_ready=0; no request is accepted while a response waits.
//
// Optional feature macro: ALU_ARB_PIPE_EN
//   defined   -> while the response drains (rsp_ready=1), a new request may be accepted in
//                that same cycle, giving 1 transaction/cycle.
//   undefined -> at most one transaction every 2 cycles.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op        requester N operand/opcode channel (N = 0, 1)
//   alu_a/alu_b/alu_op             operands driven to the shared ALU
//   alu_result/alu_zero            combinational ALU result and zero flag
//   rsp_valid/ready/id/result/zero registered response channel tagged with requester id
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   last_grant;   // requester granted most recently; the other one wins a tie
    logic   arb_en;       // arbitration allowed this cycle
    logic   gnt_vld;      // some requester is asking
    logic   gnt;          // requester selected if arbitration is allowed
    logic   accept;       // a transaction is taken on this edge

    always_comb begin
        state_nxt  = state;
        arb_en     = 1'b0;
        gnt_vld    = 1'b0;
        gnt        = 1'b0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = 4'b0000;

        case (state)
            IDLE: arb_en = 1'b1;
`ifdef ALU_ARB_PIPE_EN
            // The response register frees up this edge, so it can be refilled at once.
            HOLD: arb_en = rsp_ready;
`else
            HOLD: arb_en = 1'b0;
`endif
            default: arb_en = 1'b0;
        endcase

        // Nothing is accepted during the reset cycle; it would be lost anyway.
        if (rst) begin
            arb_en = 1'b0;
        end

        if (req0_valid && req1_valid) begin
            gnt_vld = 1'b1;
            gnt     = ~last_grant;
        end else if (req0_valid) begin
            gnt_vld = 1'b1;
            gnt     = 1'b0;
        end else if (req1_valid) begin
            gnt_vld = 1'b1;
            gnt     = 1'b1;
        end

        if (arb_en && gnt_vld) begin
            accept = 1'b1;
            if (gnt) begin
                req1_ready = 1'b1;
                alu_a      = req1_a;
                alu_b      = req1_b;
                alu_op     = req1_op;
            end else begin
                req0_ready = 1'b1;
                alu_a      = req0_a;
                alu_b      = req0_b;
                alu_op     = req0_op;
            end
        end

        if (accept) begin
            state_nxt = HOLD;
        end else if (state == HOLD && rsp_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= gnt;
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                last_grant <= gnt;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model plus directed scenarios.
// Latency: checks run on the falling edge, inputs change 1 time unit after the rising edge.
// Backpressure: rsp_ready is driven directly by the scenarios.
module tb_alu_arbiter;
    localparam int W = 32;
`ifdef ALU_ARB_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [3:0]   req0_op = 4'd0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic [3:0]   req1_op = 4'd0;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_op;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    // Reference ALU: undefined opcodes give 0.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
        logic [W-1:0] r;
        case (op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = {31'd0, $signed(a) < $signed(b)};
            4'b0011: r = {31'd0, a < b};
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);
    assign alu_zero   = (alu_result == '0);

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
    } txn_t;

    typedef struct {
        int           id;
        logic [W-1:0] res;
        logic         z;
        int           cyc;
    } rsp_t;

    txn_t q0[$];
    txn_t q1[$];
    rsp_t rcv[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic acc0 = 1'b0;
    logic acc1 = 1'b0;

    function automatic txn_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        txn_t t;
        t.a = a;
        t.b = b;
        t.op = op;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Requester drivers: present queue head, pop it once accepted.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            req0_valid = 1'b1; req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op;
        end else begin
            req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 4'd0;
        end
        if (q1.size() > 0) begin
            req1_valid = 1'b1; req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op;
        end else begin
            req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 4'd0;
        end
    end

    // Handshake observers.
    always @(negedge clk) begin
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            rsp_t r;
            r.id = int'(rsp_id);
            r.res = rsp_result;
            r.z = rsp_zero;
            r.cyc = cyc;
            rcv.push_back(r);
        end
    end

    // Transaction model: a one-entry response slot and the id of the last winner.
    bit           mdl_ok = 1'b0;
    bit           m_rv = 1'b0;
    int           m_id = 0;
    logic [W-1:0] m_res = '0;
    logic         m_z = 1'b0;
    int           m_last = 1;

    // Which requester may be taken right now (-1: none). A new request fits when the
    // slot is empty, or (pipelined build) when the slot is being drained this cycle.
    function automatic int m_grant();
        bit room;
        room = (rst === 1'b0) && (!m_rv || (PIPE && rsp_ready === 1'b1));
        if (!room) return -1;
        if (req0_valid && req1_valid) return 1 - m_last;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = m_grant();
        if (rst === 1'b1) begin
            m_rv = 1'b0; m_id = 0; m_res = '0; m_z = 1'b0; m_last = 1; mdl_ok = 1'b1;
        end else if (g >= 0) begin
            m_res  = (g == 0) ? alu_fn(req0_a, req0_b, req0_op) : alu_fn(req1_a, req1_b, req1_op);
            m_z    = (m_res == '0);
            m_id   = g;
            m_last = g;
            m_rv   = 1'b1;
        end else if (m_rv && rsp_ready === 1'b1) begin
            m_rv = 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int g;
        if (mdl_ok) begin
            g = m_grant();
            chk("req0_ready", 32'(req0_ready), 32'(g == 0));
            chk("req1_ready", 32'(req1_ready), 32'(g == 1));
            chk("alu_a", alu_a, (g == 0) ? req0_a : (g == 1) ? req1_a : '0);
            chk("alu_b", alu_b, (g == 0) ? req0_b : (g == 1) ? req1_b : '0);
            chk("alu_op", 32'(alu_op), (g == 0) ? 32'(req0_op) : (g == 1) ? 32'(req1_op) : 32'd0);
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            if (m_rv) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_zero", 32'(rsp_zero), 32'(m_z));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rcv(input string nm, input int n);
        for (int i = 0; i < 80 && rcv.size() < n; i++) @(negedge clk);
        chk(nm, 32'(rcv.size()), 32'(n));
    endtask

    task automatic wait_vld(input string nm);
        for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) @(negedge clk);
        chk(nm, 32'(rsp_valid), 32'd1);
    endtask

    logic [3:0] ops [8] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0111};

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;

        // Reset held for 2 cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset req0_ready", 32'(req0_ready), 32'd0);
        chk("reset req1_ready", 32'(req1_ready), 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        chk("reset rsp_result", rsp_result, 32'd0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Single request: ready in the same cycle, response one cycle later.
        @(negedge clk);
        q0.push_back(mk(32'd5, 32'd7, 4'b0000));
        @(negedge clk);
        chk("t2 req0_ready", 32'(req0_ready), 32'd1);
        chk("t2 req1_ready", 32'(req1_ready), 32'd0);
        chk("t2 alu_a", alu_a, 32'd5);
        @(negedge clk);
        chk("t2 rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2 rsp_id", 32'(rsp_id), 32'd0);
        chk("t2 rsp_result", rsp_result, 32'd12);
        chk("t2 rsp_zero", 32'(rsp_zero), 32'd0);
        repeat (3) @(negedge clk);

        // Tie straight after reset: requester 0 first.
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        rcv.delete();
        q0.push_back(mk(32'd9, 32'd9, 4'b1000));
        q1.push_back(mk(32'h0F0, 32'h00F, 4'b0110));
        wait_rcv("t3 count", 2);
        if (rcv.size() >= 2) begin
            chk("t3 id0", 32'(rcv[0].id), 32'd0);
            chk("t3 res0", rcv[0].res, 32'd0);
            chk("t3 zero0", 32'(rcv[0].z), 32'd1);
            chk("t3 id1", 32'(rcv[1].id), 32'd1);
            chk("t3 res1", rcv[1].res, 32'h0FF);
            chk("t3 zero1", 32'(rcv[1].z), 32'd0);
        end
        repeat (3) @(negedge clk);

        // Backpressure: response frozen, nothing accepted.
        step(); rsp_ready = 1'b0;
        @(negedge clk);
        q0.push_back(mk(32'd3, 32'd4, 4'b0000));
        wait_vld("t4 rsp arrives");
        q1.push_back(mk(32'd1, 32'd1, 4'b0000));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4 hold valid", 32'(rsp_valid), 32'd1);
            chk("t4 hold result", rsp_result, 32'd7);
            chk("t4 hold id", 32'(rsp_id), 32'd0);
            chk("t4 hold ready0", 32'(req0_ready), 32'd0);
            chk("t4 hold ready1", 32'(req1_ready), 32'd0);
        end
        step(); rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
`ifdef ALU_ARB_PIPE_EN
        chk("t4 release valid", 32'(rsp_valid), 32'd1);
        chk("t4 release result", rsp_result, 32'd2);
`else
        chk("t4 release valid", 32'(rsp_valid), 32'd0);
        chk("t4 release ready1", 32'(req1_ready), 32'd1);
`endif
        repeat (4) @(negedge clk);

        // Reset while a response is pending.
        step(); rsp_ready = 1'b0;
        @(negedge clk);
        q0.push_back(mk(32'd2, 32'd2, 4'b0000));
        wait_vld("t5 rsp arrives");
        step(); rst = 1'b1;
        @(negedge clk);
        chk("t5 rst ready0", 32'(req0_ready), 32'd0);
        chk("t5 rst ready1", 32'(req1_ready), 32'd0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t5 after rst valid", 32'(rsp_valid), 32'd0);
        chk("t5 after rst result", rsp_result, 32'd0);
        q0.push_back(mk(32'd1, 32'd1, 4'b0000));
        q1.push_back(mk(32'd2, 32'd2, 4'b0000));
        rcv.delete();
        step(); rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5 tie ready0", 32'(req0_ready), 32'd1);
        chk("t5 tie ready1", 32'(req1_ready), 32'd0);
        wait_rcv("t5 count", 2);
        repeat (3) @(negedge clk);

        // Undefined opcode forwarded; ALU gives 0.
        rcv.delete();
        q1.push_back(mk(32'd5, 32'd5, 4'b1111));
        wait_rcv("t6 count", 1);
        if (rcv.size() >= 1) begin
            chk("t6 id", 32'(rcv[0].id), 32'd1);
            chk("t6 res", rcv[0].res, 32'd0);
            chk("t6 zero", 32'(rcv[0].z), 32'd1);
        end
        repeat (3) @(negedge clk);

        // Throughput with both requesters saturated.
        rcv.delete();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mk(32'd1, 32'd4, 4'b0001));
            q1.push_back(mk(32'h8000_0000, 32'd4, 4'b1101));
        end
        wait_rcv("t7 count", 12);
        if (rcv.size() >= 12) begin
            chk("t7 first id", 32'(rcv[0].id), 32'd0);
            for (int i = 0; i < 12; i++) begin
                chk("t7 res", rcv[i].res, (rcv[i].id == 1) ? 32'hF800_0000 : 32'h0000_0010);
                if (i > 0) begin
                    chk("t7 alternate", 32'(rcv[i].id), 32'(1 - rcv[i-1].id));
                    chk("t7 spacing", 32'(rcv[i].cyc - rcv[i-1].cyc), PIPE ? 32'd1 : 32'd2);
                end
            end
        end
        repeat (3) @(negedge clk);

        // Mixed traffic under a fixed backpressure pattern, model-checked each cycle.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) q0.push_back(mk(32'(i * 3 + 1), 32'(i + 1), ops[i]));
            else            q1.push_back(mk(32'(i * 5), 32'(i), ops[i]));
        end
        for (int i = 0; i < 30; i++) begin
            step();
            rsp_ready = (i % 3 != 0);
        end
        step(); rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("t8 drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
